// File: rtl/serial_mod_pkg.sv
// Shared types and constants for the serial modulo checker family.
package serial_mod_pkg;

   // Frame-level FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   localparam int unsigned DIV_MAX_DEF = 16;
   localparam int unsigned CNT_W_DEF   = 8;

   // Reset values for state and single-bit flags
   localparam state_t RST_STATE = ST_IDLE;
   localparam logic   RST_FLAG  = 1'b0;

   // Remainder width: enough bits to hold any remainder below div_max
   function automatic int unsigned rem_w_of(input int unsigned div_max);
      return (div_max < 2) ? 1 : $clog2(div_max);
   endfunction

endpackage

// File: rtl/serial_mod_checker_mod2_step.sv
// One MSB-first modulo step: next = (2*rem + data_bit) mod div, given rem < div.
module mod2_step
   import serial_mod_pkg::*;
#(
   parameter int unsigned REM_W = 4
)(
   input  logic [REM_W-1:0] rem_cur,
   input  logic             data_bit,
   input  logic [REM_W:0]   div,
   output logic [REM_W-1:0] rem_nxt
);

   logic [REM_W+1:0] t_c;
   logic [REM_W+1:0] div_ext_c;

   // Shift in the new bit and subtract the divisor at most once
   always_comb begin
      t_c       = {1'b0, rem_cur, data_bit};
      div_ext_c = (REM_W+2)'(div);
      if (t_c >= div_ext_c) begin
         rem_nxt = REM_W'(t_c - div_ext_c);
      end else begin
         rem_nxt = REM_W'(t_c);
      end
   end

endmodule

// File: rtl/serial_mod_checker.sv
// Frame-based serial remainder tracker with a run-time divisor.
module serial_mod_checker
   import serial_mod_pkg::*;
#(
   parameter int unsigned DIV_MAX = DIV_MAX_DEF,
   parameter int unsigned REM_W   = rem_w_of(DIV_MAX),
   parameter int unsigned CNT_W   = CNT_W_DEF
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             in_start,
   input  logic             in_last,
   input  logic [REM_W:0]   div_in,
   output logic [REM_W-1:0] rem,
   output logic             divisible,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             busy,
   output logic             res_valid,
   output logic             err
);

   state_t           state;
   logic [REM_W:0]   div_q;

   logic             start_c;
   logic             div_legal_c;
   logic [REM_W-1:0] step_rem_in_c;
   logic [REM_W:0]   step_div_c;
   logic [REM_W-1:0] step_rem_c;
   logic [CNT_W-1:0] cnt_inc_c;

   // A start restarts the remainder from zero with the freshly presented divisor
   assign start_c       = in_valid & in_start;
   assign div_legal_c   = (div_in != '0) && (div_in <= (REM_W+1)'(DIV_MAX));
   assign step_rem_in_c = start_c ? '0 : rem;
   assign step_div_c    = start_c ? div_in : div_q;
   assign cnt_inc_c     = (bit_cnt == {CNT_W{1'b1}}) ? bit_cnt : bit_cnt + CNT_W'(1);

   mod2_step #(.REM_W(REM_W)) u_step (
      .rem_cur  (step_rem_in_c),
      .data_bit (in_bit),
      .div      (step_div_c),
      .rem_nxt  (step_rem_c)
   );

   // Frame FSM, divisor latch, counter and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= RST_STATE;
         div_q     <= '0;
         rem       <= '0;
         divisible <= RST_FLAG;
         bit_cnt   <= '0;
         busy      <= RST_FLAG;
         res_valid <= RST_FLAG;
         err       <= RST_FLAG;
      end else begin
         res_valid <= 1'b0;
         if (start_c) begin
            div_q     <= div_in;
            busy      <= ~in_last;
            res_valid <= in_last;
            if (div_legal_c) begin
               rem       <= step_rem_c;
               bit_cnt   <= CNT_W'(1);
               err       <= 1'b0;
               divisible <= (step_rem_c == '0);
               state     <= in_last ? ST_DONE : ST_RUN;
            end else begin
               // Illegal divisor: the whole frame, start bit included, is ignored
               rem       <= '0;
               bit_cnt   <= '0;
               err       <= 1'b1;
               divisible <= 1'b0;
               state     <= in_last ? ST_DONE : ST_ERR;
            end
         end else begin
            case (state)
               ST_RUN: begin
                  if (in_valid) begin
                     rem       <= step_rem_c;
                     bit_cnt   <= cnt_inc_c;
                     divisible <= (step_rem_c == '0);
                     if (in_last) begin
                        state     <= ST_DONE;
                        busy      <= 1'b0;
                        res_valid <= 1'b1;
                     end
                  end
               end
               ST_ERR: begin
                  if (in_valid && in_last) begin
                     state     <= ST_DONE;
                     busy      <= 1'b0;
                     res_valid <= 1'b1;
                  end
               end
               ST_DONE: begin
                  state <= ST_IDLE;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_mod_checker.sv
// Randomized and directed bench for serial_mod_checker against a frame-level model.
module tb_serial_mod_checker;

   localparam int unsigned DIV_MAX = 16;
   localparam int unsigned REM_W   = 4;
   localparam int unsigned CNT_W   = 8;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_bit;
   logic             in_start;
   logic             in_last;
   logic [REM_W:0]   div_in;

   logic [REM_W-1:0] rem;
   logic             divisible;
   logic [CNT_W-1:0] bit_cnt;
   logic             busy;
   logic             res_valid;
   logic             err;

   logic [REM_W-1:0] s_rem;
   logic             s_divisible;
   logic [1:0]       s_bit_cnt;
   logic             s_busy;
   logic             s_res_valid;
   logic             s_err;

   int tests;
   int fails;

   // Frame-level reference state
   bit m_open;
   bit m_err;
   bit m_rv;
   int m_d;
   int m_rem;
   int m_cnt;
   int m_cnt2;

   serial_mod_checker #(.DIV_MAX(DIV_MAX), .CNT_W(CNT_W)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .in_start  (in_start),
      .in_last   (in_last),
      .div_in    (div_in),
      .rem       (rem),
      .divisible (divisible),
      .bit_cnt   (bit_cnt),
      .busy      (busy),
      .res_valid (res_valid),
      .err       (err)
   );

   serial_mod_checker #(.DIV_MAX(DIV_MAX), .CNT_W(2)) u_sat (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .in_start  (in_start),
      .in_last   (in_last),
      .div_in    (div_in),
      .rem       (s_rem),
      .divisible (s_divisible),
      .bit_cnt   (s_bit_cnt),
      .busy      (s_busy),
      .res_valid (s_res_valid),
      .err       (s_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, advance the model, then compare all outputs
   task automatic cyc(input bit rst_n, input bit v, input bit b, input bit s, input bit l,
                      input int d);
      reset    = rst_n;
      in_valid = v;
      in_bit   = b;
      in_start = s;
      in_last  = l;
      div_in   = (REM_W+1)'(d);
      m_rv     = 1'b0;
      if (!rst_n) begin
         m_open = 0; m_err = 0; m_d = 0; m_rem = 0; m_cnt = 0; m_cnt2 = 0;
      end else if (v && s) begin
         m_d = d;
         if (d == 0 || d > int'(DIV_MAX)) begin
            m_err = 1; m_rem = 0; m_cnt = 0; m_cnt2 = 0;
         end else begin
            m_err = 0; m_rem = int'(b) % d; m_cnt = 1; m_cnt2 = 1;
         end
         m_open = !l;
         m_rv   = l;
      end else if (m_open && v) begin
         if (!m_err) begin
            m_rem  = (2 * m_rem + int'(b)) % m_d;
            m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
         end
         if (l) begin
            m_open = 0;
            m_rv   = 1;
         end
      end
      @(posedge clk);
      #1;
      check("rem", 32'(rem), 32'(m_rem));
      check("divisible", 32'(divisible), 32'((m_rem == 0) && (m_cnt != 0) && !m_err));
      check("bit_cnt", 32'(bit_cnt), 32'(m_cnt));
      check("busy", 32'(busy), 32'(m_open));
      check("res_valid", 32'(res_valid), 32'(m_rv));
      check("err", 32'(err), 32'(m_err));
      check("sat_bit_cnt", 32'(s_bit_cnt), 32'(m_cnt2));
      check("sat_rem", 32'(s_rem), 32'(m_rem));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int d;
      tests = 0;
      fails = 0;
      reset = 1'b0; in_valid = 0; in_bit = 0; in_start = 0; in_last = 0; div_in = '0;

      // Reset state
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 1, 1, 1, 0, 5);
      check("reset_rem", 32'(rem), 32'd0);

      // d=5, 1010 -> rem 1,2,0,0 and divisible
      cyc(1, 1, 1, 1, 0, 5); check("t1_rem1", 32'(rem), 32'd1);
      cyc(1, 1, 0, 0, 0, 0); check("t1_rem2", 32'(rem), 32'd2);
      cyc(1, 1, 1, 0, 0, 0); check("t1_rem3", 32'(rem), 32'd0);
      cyc(1, 1, 0, 0, 1, 0);
      check("t1_rem4", 32'(rem), 32'd0);
      check("t1_div", 32'(divisible), 32'd1);
      check("t1_rv", 32'(res_valid), 32'd1);
      check("t1_cnt", 32'(bit_cnt), 32'd4);
      idle(1); check("t1_rv_pulse", 32'(res_valid), 32'd0);
      idle(1);

      // d=7, 1101 with a gap after bit 2 -> rem 1,3,3,6,6
      cyc(1, 1, 1, 1, 0, 7); check("t2_rem1", 32'(rem), 32'd1);
      cyc(1, 1, 1, 0, 0, 0); check("t2_rem2", 32'(rem), 32'd3);
      idle(3);               check("t2_hold", 32'(rem), 32'd3);
      cyc(1, 1, 0, 0, 0, 0); check("t2_rem3", 32'(rem), 32'd6);
      cyc(1, 1, 1, 0, 1, 0);
      check("t2_rem4", 32'(rem), 32'd6);
      check("t2_div", 32'(divisible), 32'd0);
      check("t2_cnt", 32'(bit_cnt), 32'd4);
      idle(2);

      // d=0 frame, then legal d=3 start clears err
      cyc(1, 1, 1, 1, 0, 0);
      cyc(1, 1, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 1, 0);
      check("t3_err", 32'(err), 32'd1);
      check("t3_rv", 32'(res_valid), 32'd1);
      check("t3_rem", 32'(rem), 32'd0);
      cyc(1, 1, 1, 1, 0, 3);
      check("t3_err_clr", 32'(err), 32'd0);
      check("t3_rem_new", 32'(rem), 32'd1);
      cyc(1, 1, 0, 0, 1, 0);
      idle(2);

      // Abort in RUN: d=5 bits 1,1 then restart with bit 0
      cyc(1, 1, 1, 1, 0, 5);
      cyc(1, 1, 1, 0, 0, 0);
      cyc(1, 1, 0, 1, 0, 5);
      check("t4_rv", 32'(res_valid), 32'd0);
      check("t4_cnt", 32'(bit_cnt), 32'd1);
      check("t4_div", 32'(divisible), 32'd1);

      // Mid-frame reset with d=9, then stray bits ignored
      cyc(1, 1, 1, 1, 0, 9);
      cyc(1, 1, 1, 0, 0, 0);
      cyc(0, 1, 1, 0, 0, 0);
      check("t5_busy", 32'(busy), 32'd0);
      cyc(1, 1, 1, 0, 0, 0);
      cyc(1, 1, 1, 0, 1, 0);
      check("t5_cnt", 32'(bit_cnt), 32'd0);

      // d=1 single-bit frame
      cyc(1, 1, 1, 1, 1, 1);
      check("t6_div", 32'(divisible), 32'd1);
      check("t6_cnt", 32'(bit_cnt), 32'd1);
      check("t6_rv", 32'(res_valid), 32'd1);

      // Long frame: 2-bit counter saturates at 3, 8-bit counter at 255
      cyc(1, 1, 1, 1, 0, 13);
      for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 0, 0);
      check("t7_sat2", 32'(s_bit_cnt), 32'd3);
      for (int i = 0; i < 295; i++) cyc(1, 1, 32'($urandom_range(0, 1)) != 0, 0, 0, 0);
      check("t7_sat8", 32'(bit_cnt), 32'd255);
      cyc(1, 1, 0, 0, 1, 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31))
                                          : int'($urandom_range(1, DIV_MAX));
         cyc($urandom_range(0, 99) != 0,
             $urandom_range(0, 9) < 7,
             $urandom_range(0, 1) != 0,
             $urandom_range(0, 9) == 0,
             $urandom_range(0, 9) < 1,
             d);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
